// File: rtl/aes_key_expand.sv
// aes_key_expand: iterative AES-128 key-expansion engine.
// Walks rounds 1..NR, two cycles per round (FETCH the round constant, then
// EXPAND), emitting every round key from the cipher key (round 0) onward.
//
// Build option: define AES_KEY_EXPAND_INTERNAL_RCON_EN to take the round
// constant from an internal table instead of the external RCON memory; the
// read port is then held idle and rcon_data is ignored.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; current rk_out is held
// FETCH  | RCON read strobe for round rk_round+1 is on the port
// EXPAND | RCON data valid; next round key is registered

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] xx;
        p  = 8'h00;
        xx = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ xx;
            xx = {xx[6:0], 1'b0} ^ (xx[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x14, inv;

    // Multiplicative inverse as a^254 (0 maps to 0 naturally).
    assign x2   = gf_mul(a, a);
    assign x3   = gf_mul(x2, a);
    assign x6   = gf_mul(x3, x3);
    assign x12  = gf_mul(x6, x6);
    assign x15  = gf_mul(x12, x3);
    assign x30  = gf_mul(x15, x15);
    assign x60  = gf_mul(x30, x30);
    assign x120 = gf_mul(x60, x60);
    assign x240 = gf_mul(x120, x120);
    assign x14  = gf_mul(x12, x2);
    assign inv  = gf_mul(x240, x14);

    // Affine transform over the inverse.
    assign s = inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;
endmodule

module aes_key_expand #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         rcon_rd_en,
    output logic [7:0]   rcon_addr,
    input  logic [7:0]   rcon_data,
    output logic         busy,
    output logic         rk_valid,
    output logic [3:0]   rk_round,
    output logic [127:0] rk_out,
    output logic         done
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_EXPAND = 2'd2
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NR - 1);

    state_t state, state_nxt;

    logic [31:0]  w0, w1, w2, w3, rot_w, sub_w, t_w;
    logic [31:0]  n0, n1, n2, n3;
    logic [7:0]   rcon_val;

    assign w0 = rk_out[127:96];
    assign w1 = rk_out[95:64];
    assign w2 = rk_out[63:32];
    assign w3 = rk_out[31:0];

    assign rot_w = {w3[23:0], w3[31:24]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            aes_sbox u_sbox (
                .a (rot_w[8*gi +: 8]),
                .s (sub_w[8*gi +: 8])
            );
        end
    endgenerate

`ifdef AES_KEY_EXPAND_INTERNAL_RCON_EN
    logic rcon_unused;
    assign rcon_unused = ^rcon_data;

    // Round constant straight from the fixed table, indexed by current round.
    always_comb begin
        rcon_val = 8'h00;
        case (rk_round)
            4'd0:    rcon_val = 8'h01;
            4'd1:    rcon_val = 8'h02;
            4'd2:    rcon_val = 8'h04;
            4'd3:    rcon_val = 8'h08;
            4'd4:    rcon_val = 8'h10;
            4'd5:    rcon_val = 8'h20;
            4'd6:    rcon_val = 8'h40;
            4'd7:    rcon_val = 8'h80;
            4'd8:    rcon_val = 8'h1b;
            4'd9:    rcon_val = 8'h36;
            default: rcon_val = 8'h00;
        endcase
    end
`else
    assign rcon_val = rcon_data;
`endif

    assign t_w = sub_w ^ {rcon_val, 24'h000000};
    assign n0  = w0 ^ t_w;
    assign n1  = w1 ^ n0;
    assign n2  = w2 ^ n1;
    assign n3  = w3 ^ n2;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_EXPAND;
            S_EXPAND: state_nxt = (rk_round == LAST_IDX) ? S_IDLE : S_FETCH;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // RCON read port is only active in FETCH.
    always_comb begin
        rcon_rd_en = 1'b0;
        rcon_addr  = 8'h00;
`ifndef AES_KEY_EXPAND_INTERNAL_RCON_EN
        if (state == S_FETCH) begin
            rcon_rd_en = 1'b1;
            rcon_addr  = {4'h0, rk_round};
        end
`endif
    end

    // Round-key register, round counter and status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rk_out   <= '0;
            rk_round <= 4'd0;
            rk_valid <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            rk_valid <= 1'b0;
            done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        rk_out   <= key_in;
                        rk_round <= 4'd0;
                        rk_valid <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                S_EXPAND: begin
                    rk_out   <= {n0, n1, n2, n3};
                    rk_round <= rk_round + 4'd1;
                    rk_valid <= 1'b1;
                    if (rk_round == LAST_IDX) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: randomized and known-answer keys checked against
// a word-oriented FIPS-197 key schedule model; also checks port timing,
// start-while-busy handling and asynchronous reset abort.
// Honors AES_KEY_EXPAND_INTERNAL_RCON_EN (rcon_data tied to ff).

module tb_aes_key_expand;
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         rcon_rd_en;
    logic [7:0]   rcon_addr;
    logic [7:0]   rcon_data;
    logic         busy;
    logic         rk_valid;
    logic [3:0]   rk_round;
    logic [127:0] rk_out;
    logic         done;

    aes_key_expand #(.NR(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .key_in     (key_in),
        .rcon_rd_en (rcon_rd_en),
        .rcon_addr  (rcon_addr),
        .rcon_data  (rcon_data),
        .busy       (busy),
        .rk_valid   (rk_valid),
        .rk_round   (rk_round),
        .rk_out     (rk_out),
        .done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] rcon_mem [0:255];
`ifdef AES_KEY_EXPAND_INTERNAL_RCON_EN
    assign rcon_data = 8'hff;
`else
    initial rcon_data = 8'h00;
    always @(posedge clk) if (rcon_rd_en) rcon_data <= rcon_mem[rcon_addr];
`endif

    // Event logs gathered at the falling edge.
    int           v_cyc [$];
    logic [3:0]   v_round [$];
    logic [127:0] v_key [$];
    int           d_cyc [$];
    logic         d_ok [$];
    int           s_cyc [$];
    logic [7:0]   s_addr [$];

    always @(negedge clk) begin
        if (rk_valid) begin
            v_cyc.push_back(cyc);
            v_round.push_back(rk_round);
            v_key.push_back(rk_out);
        end
        if (done) begin
            d_cyc.push_back(cyc);
            d_ok.push_back(rk_valid && (rk_round == 4'd10));
        end
        if (rcon_rd_en) begin
            s_cyc.push_back(cyc);
            s_addr.push_back(rcon_addr);
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // S-box table built by walking GF(2^8) with generator 3 and its inverse.
    logic [7:0] sbox_t [0:255];

    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        for (int i = 0; i < 255; i++) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_t[p] = x ^ 8'h63;
        end
        sbox_t[0] = 8'h63;
    endtask

    logic [127:0] model_rk [0:10];

    task automatic compute_model(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] tmp;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]}
                      ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r <= 10; r++)
            model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic clear_logs();
        v_cyc.delete(); v_round.delete(); v_key.delete();
        d_cyc.delete(); d_ok.delete(); s_cyc.delete(); s_addr.delete();
    endtask

    int e0;

    // Present start for exactly one edge; scramble key_in afterwards.
    task automatic start_pulse(input logic [127:0] k);
        @(negedge clk);
        start  = 1'b1;
        key_in = k;
        @(posedge clk);
        #1;
        e0     = cyc;
        start  = 1'b0;
        key_in = rand_key();
    endtask

    task automatic wait_valid_count(input int n, input int bound);
        int t;
        t = 0;
        while (v_key.size() < n && t < bound) begin
            @(posedge clk);
            t++;
        end
        repeat (2) @(posedge clk);
        check("valid_count", v_key.size(), n);
    endtask

    task automatic check_run(input string nm, input logic [127:0] k, input int base, input int es);
        compute_model(k);
        if (v_key.size() >= base + 11) begin
            for (int r = 0; r <= 10; r++) begin
                check($sformatf("%s_key_r%0d", nm, r), v_key[base+r], model_rk[r]);
                check($sformatf("%s_round_r%0d", nm, r), v_round[base+r], r);
                check($sformatf("%s_cycle_r%0d", nm, r), v_cyc[base+r], es + 2*r);
            end
        end else begin
            check({nm, "_enough_keys"}, v_key.size(), base + 11);
        end
    endtask

    task automatic check_strobes(input string nm, input int base, input int es);
`ifdef AES_KEY_EXPAND_INTERNAL_RCON_EN
        check({nm, "_no_strobes"}, s_cyc.size(), 0);
`else
        if (s_cyc.size() >= base + 10) begin
            for (int r = 0; r < 10; r++) begin
                check($sformatf("%s_strobe_addr%0d", nm, r), s_addr[base+r], r);
                check($sformatf("%s_strobe_cyc%0d", nm, r), s_cyc[base+r], es + 2*r);
            end
        end else begin
            check({nm, "_enough_strobes"}, s_cyc.size(), base + 10);
        end
`endif
    endtask

    task automatic full_run(input string nm, input logic [127:0] k);
        int es;
        clear_logs();
        start_pulse(k);
        es = e0;
        check({nm, "_busy_after_start"}, busy, 1'b1);
        wait_valid_count(11, 40);
        check_run(nm, k, 0, es);
        check({nm, "_done_count"}, d_cyc.size(), 1);
        if (d_cyc.size() > 0) begin
            check({nm, "_done_cycle"}, d_cyc[0], es + 20);
            check({nm, "_done_with_r10"}, d_ok[0], 1'b1);
        end
        check_strobes(nm, 0, es);
`ifdef AES_KEY_EXPAND_INTERNAL_RCON_EN
        check({nm, "_strobe_count"}, s_cyc.size(), 0);
`else
        check({nm, "_strobe_count"}, s_cyc.size(), 10);
`endif
        @(negedge clk);
        check({nm, "_busy_after_done"}, busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] k1, k2, k3;
        int es;
        rst    = 1'b0;
        start  = 1'b0;
        key_in = '0;
        for (int i = 0; i < 256; i++) rcon_mem[i] = 8'h00;
        rcon_mem[0] = 8'h01; rcon_mem[1] = 8'h02; rcon_mem[2] = 8'h04; rcon_mem[3] = 8'h08;
        rcon_mem[4] = 8'h10; rcon_mem[5] = 8'h20; rcon_mem[6] = 8'h40; rcon_mem[7] = 8'h80;
        rcon_mem[8] = 8'h1b; rcon_mem[9] = 8'h36;
        build_sbox();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rk_out", rk_out, 0);
        check("rst_rk_round", rk_round, 0);
        check("rst_rk_valid", rk_valid, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_rcon_rd_en", rcon_rd_en, 0);
        check("rst_rcon_addr", rcon_addr, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // FIPS-197 key, known answers.
        full_run("fips", 128'h2b7e151628aed2a6abf7158809cf4f3c);
        if (v_key.size() == 11) begin
            check("fips_r1_known", v_key[1], 128'ha0fafe1788542cb123a339392a6c7605);
            check("fips_r10_known", v_key[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        end else begin
            check("fips_known_count", v_key.size(), 11);
        end

        // Zero key, known answers.
        full_run("zero", 128'h0);
        if (v_key.size() == 11) begin
            check("zero_r1_known", v_key[1], 128'h62636363626363636263636362636363);
            check("zero_r10_known", v_key[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        end else begin
            check("zero_known_count", v_key.size(), 11);
        end

        // Random keys.
        for (int n = 0; n < 4; n++) begin
            full_run($sformatf("rand%0d", n), rand_key());
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        // start while busy: E0+5 and E0+20 ignored, E0+21 accepted.
        k1 = rand_key();
        k2 = rand_key();
        k3 = rand_key();
        clear_logs();
        start_pulse(k1);
        es = e0;
        while (cyc < es + 4) @(negedge clk);
        start  = 1'b1;
        key_in = k2;
        @(posedge clk);
        #1;
        start  = 1'b0;
        while (cyc < es + 19) @(negedge clk);
        start  = 1'b1;
        key_in = k3;
        @(posedge clk);
        @(posedge clk);
        #1;
        start  = 1'b0;
        key_in = rand_key();
        wait_valid_count(22, 60);
        check_run("busy_first", k1, 0, es);
        check_run("busy_second", k3, 11, es + 21);
        check("busy_done_count", d_cyc.size(), 2);
        if (d_cyc.size() == 2) begin
            check("busy_done0_cycle", d_cyc[0], es + 20);
            check("busy_done1_cycle", d_cyc[1], es + 41);
        end
        check_strobes("busy_first", 0, es);
        check_strobes("busy_second", 10, es + 21);

        // Asynchronous reset mid-run.
        clear_logs();
        start_pulse(rand_key());
        es = e0;
        while (cyc < es + 7) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("abort_rk_out", rk_out, 0);
        check("abort_rk_round", rk_round, 0);
        check("abort_rk_valid", rk_valid, 0);
        check("abort_done", done, 0);
        check("abort_busy", busy, 0);
        check("abort_rcon_rd_en", rcon_rd_en, 0);
        check("abort_rcon_addr", rcon_addr, 0);
        check("abort_keys_before", v_key.size(), 4);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check("abort_no_done", d_cyc.size(), 0);
        check("abort_no_more_keys", v_key.size(), 4);
        check("abort_idle_busy", busy, 0);
        full_run("after_abort", rand_key());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
